// File: rtl/aligner_pkg.sv
// Shared constants and helpers for the aligner output buffer.
// DATA_WIDTH  : default output beat width in bits
// KEEP_WIDTH  : byte-valid mask width (DATA_WIDTH/8)
// ENTRY_WIDTH : FIFO entry width {data, keep, last}
// keep_popcount() : number of set bits in a keep mask, as a 32-bit count
package aligner_pkg;

   localparam int unsigned DATA_WIDTH  = 256;
   localparam int unsigned KEEP_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

   function automatic logic [31:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         n = n + 32'(keep[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/aligner_out_buffer_if.sv
// AXI4-Stream beat interface driven by the aligner output buffer.
// tdata/tkeep/tlast/tvalid : beat from master to slave
// tready                   : backpressure from slave to master
interface aligner_out_buffer_if #(
   parameter int unsigned DATA_WIDTH = 256
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/aligner_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH, one synchronous write port, asynchronous read.
// clk     : write clock
// wr_en   : write strobe, wr_addr/wr_data : write address and entry
// rd_addr : read address, rd_data : combinational read of that entry
// Contents are deliberately not reset.
module aligner_fifo_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 289
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aligner_out_buffer.sv
// First-word-fall-through output FIFO between the aligner and an AXI4-Stream sink.
// clk, reset_n       : clock and asynchronous active-low reset
// in_data/in_tkeep   : aligned beat and byte mask from the aligner
// in_flags           : {valid, stall, tlast} from the aligner
// wrt_en             : registered advance enable back to the aligner (leaves SKID slots free)
// m_axis             : AXI4-Stream master port
// pkt_len/_valid     : byte count of each completed packet and its one-cycle strobe
// overflow_err       : sticky flag, a valid beat arrived with no room
// stall_cnt          : saturating count of cycles with valid and stall both set
// DATA_WIDTH must not exceed aligner_pkg::DATA_WIDTH (keep_popcount mask width).
module aligner_out_buffer
   import aligner_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = aligner_pkg::DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned SKID       = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [DATA_WIDTH/8-1:0] in_tkeep,
   input  logic [2:0]              in_flags,
   output logic                    wrt_en,
   aligner_out_buffer_if.master    m_axis,
   output logic [31:0]             pkt_len,
   output logic                    pkt_len_valid,
   output logic                    overflow_err,
   output logic [15:0]             stall_cnt
);

   localparam int unsigned KeepWidth  = DATA_WIDTH / 8;
   localparam int unsigned EntryWidth = DATA_WIDTH + KeepWidth + 1;
   localparam int unsigned AddrWidth  = $clog2(DEPTH);
   localparam int unsigned CntWidth   = AddrWidth + 1;
   localparam logic [CntWidth-1:0] FullCnt = CntWidth'(DEPTH);
   localparam logic [CntWidth-1:0] SkidCnt = CntWidth'(SKID);

   logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0]   count_q, count_d;
   logic                  wrt_en_q, wrt_en_d;
   logic [31:0]           acc_q, acc_d;
   logic [31:0]           pkt_len_q, pkt_len_d;
   logic                  pkt_len_valid_q, pkt_len_valid_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           stall_cnt_q, stall_cnt_d;

   logic                  push, pop;
   logic [EntryWidth-1:0] head;
   logic [DATA_WIDTH-1:0] head_data;
   logic [KeepWidth-1:0]  head_keep;
   logic                  head_last;
   logic [KEEP_WIDTH-1:0] head_keep_ext;
   logic [31:0]           beat_bytes;

   aligner_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EntryWidth)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data ({in_data, in_tkeep, in_flags[0]}),
      .rd_addr (rd_ptr_q),
      .rd_data (head)
   );

   assign head_data = head[EntryWidth-1 -: DATA_WIDTH];
   assign head_keep = head[KeepWidth:1];
   assign head_last = head[0];

   always_comb begin
      head_keep_ext                = '0;
      head_keep_ext[KeepWidth-1:0] = head_keep;
   end

   assign beat_bytes = keep_popcount(head_keep_ext);

   assign m_axis.tvalid = (count_q != '0);
   assign m_axis.tdata  = head_data;
   assign m_axis.tkeep  = head_keep;
   assign m_axis.tlast  = head_last;

   assign pop = m_axis.tvalid & m_axis.tready;

   always_comb begin
      // A pop in the same cycle frees the slot a full FIFO needs for the push.
      push = in_flags[2] & ((count_q != FullCnt) | pop);

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      wrt_en_d = (FullCnt - count_d) > SkidCnt;

      acc_d           = acc_q;
      pkt_len_d       = pkt_len_q;
      pkt_len_valid_d = 1'b0;
      if (pop) begin
         if (head_last) begin
            pkt_len_d       = acc_q + beat_bytes;
            pkt_len_valid_d = 1'b1;
            acc_d           = '0;
         end else begin
            acc_d = acc_q + beat_bytes;
         end
      end

      overflow_d = overflow_q | (in_flags[2] & ~push);

      stall_cnt_d = stall_cnt_q;
      if (in_flags[2] && in_flags[1] && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         wrt_en_q        <= 1'b1;
         acc_q           <= '0;
         pkt_len_q       <= '0;
         pkt_len_valid_q <= 1'b0;
         overflow_q      <= 1'b0;
         stall_cnt_q     <= '0;
      end else begin
         // Pointers wrap naturally: DEPTH is a power of two.
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q         <= count_d;
         wrt_en_q        <= wrt_en_d;
         acc_q           <= acc_d;
         pkt_len_q       <= pkt_len_d;
         pkt_len_valid_q <= pkt_len_valid_d;
         overflow_q      <= overflow_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign wrt_en        = wrt_en_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_len_valid = pkt_len_valid_q;
   assign overflow_err  = overflow_q;
   assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_aligner_out_buffer.sv
// Directed bench for aligner_out_buffer (DATA_WIDTH=256, DEPTH=16, SKID=3).
module tb_aligner_out_buffer;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [255:0] in_data = '0;
   logic [31:0]  in_tkeep = '0;
   logic [2:0]   in_flags = '0;
   logic         wrt_en;
   logic [31:0]  pkt_len;
   logic         pkt_len_valid;
   logic         overflow_err;
   logic [15:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   aligner_out_buffer_if #(.DATA_WIDTH(256)) axis ();

   aligner_out_buffer #(
      .DATA_WIDTH (256),
      .DEPTH      (16),
      .SKID       (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_data       (in_data),
      .in_tkeep      (in_tkeep),
      .in_flags      (in_flags),
      .wrt_en        (wrt_en),
      .m_axis        (axis),
      .pkt_len       (pkt_len),
      .pkt_len_valid (pkt_len_valid),
      .overflow_err  (overflow_err),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] pat(input int id);
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(id);
      return {8{w}};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input int id, input logic [31:0] k);
      in_flags = f;
      in_data  = pat(id);
      in_tkeep = k;
   endtask

   initial begin
      axis.tready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_wrt_en", 256'(wrt_en), 256'(1));
      chk("rst_tvalid", 256'(axis.tvalid), 256'(0));
      chk("rst_pkt_len", 256'(pkt_len), 256'(0));
      chk("rst_pkt_valid", 256'(pkt_len_valid), 256'(0));
      chk("rst_overflow", 256'(overflow_err), 256'(0));
      chk("rst_stall", 256'(stall_cnt), 256'(0));
      reset_n = 1'b1;
      tick();

      // Single packet: 32 + 32 + 4 bytes
      axis.tready = 1'b1;
      drive(3'b100, 0, 32'hFFFF_FFFF);
      tick();
      chk("pkt_b0_valid", 256'(axis.tvalid), 256'(1));
      chk("pkt_b0_data", axis.tdata, pat(0));
      chk("pkt_b0_last", 256'(axis.tlast), 256'(0));
      drive(3'b100, 1, 32'hFFFF_FFFF);
      tick();
      chk("pkt_b1_data", axis.tdata, pat(1));
      drive(3'b101, 2, 32'h0000_000F);
      tick();
      chk("pkt_b2_data", axis.tdata, pat(2));
      chk("pkt_b2_keep", 256'(axis.tkeep), 256'(32'h0000_000F));
      chk("pkt_b2_last", 256'(axis.tlast), 256'(1));
      chk("pkt_no_early_strobe", 256'(pkt_len_valid), 256'(0));
      drive(3'b000, 0, 32'h0);
      tick();
      chk("pkt_strobe", 256'(pkt_len_valid), 256'(1));
      chk("pkt_len_68", 256'(pkt_len), 256'(68));
      chk("pkt_empty", 256'(axis.tvalid), 256'(0));
      tick();
      chk("pkt_strobe_one_cycle", 256'(pkt_len_valid), 256'(0));
      chk("pkt_len_hold", 256'(pkt_len), 256'(68));

      // Backpressure: fill to 13, then to 16
      axis.tready = 1'b0;
      for (int i = 0; i < 13; i++) begin
         drive(3'b100, i, 32'hFFFF_FFFF);
         tick();
         if (i == 11) chk("bp_wrt_en_at_12", 256'(wrt_en), 256'(1));
      end
      chk("bp_wrt_en_at_13", 256'(wrt_en), 256'(0));
      for (int i = 13; i < 16; i++) begin
         drive(3'b100, i, 32'hFFFF_FFFF);
         tick();
      end
      chk("bp_count_16", 256'(dut.count_q), 256'(16));
      chk("bp_no_overflow", 256'(overflow_err), 256'(0));
      chk("bp_head_stable", axis.tdata, pat(0));
      drive(3'b000, 0, 32'h0);
      axis.tready = 1'b1;
      tick();
      axis.tready = 1'b0;
      chk("bp_count_15", 256'(dut.count_q), 256'(15));
      chk("bp_head_after_pop", axis.tdata, pat(1));
      drive(3'b100, 16, 32'hFFFF_FFFF);
      tick();
      chk("bp_refill_16", 256'(dut.count_q), 256'(16));

      // Overflow: full, no pop, one more beat
      drive(3'b100, 99, 32'hFFFF_FFFF);
      tick();
      chk("ovf_flag", 256'(overflow_err), 256'(1));
      chk("ovf_count", 256'(dut.count_q), 256'(16));
      drive(3'b000, 0, 32'h0);
      tick();
      chk("ovf_sticky", 256'(overflow_err), 256'(1));
      chk("ovf_head", axis.tdata, pat(1));

      // Simultaneous push and pop while full
      drive(3'b100, 17, 32'hFFFF_FFFF);
      axis.tready = 1'b1;
      tick();
      drive(3'b000, 0, 32'h0);
      for (int k = 0; k < 16; k++) begin
         chk("drain_count", 256'(dut.count_q), 256'(16 - k));
         chk("drain_wrt_en", 256'(wrt_en), 256'(k > 3));
         chk("drain_data", axis.tdata, pat(k + 2));
         tick();
      end
      chk("drain_empty", 256'(axis.tvalid), 256'(0));
      chk("drain_no_strobe", 256'(pkt_len_valid), 256'(0));
      chk("drain_len_hold", 256'(pkt_len), 256'(68));

      // Mid-packet reset
      axis.tready = 1'b0;
      for (int i = 20; i < 34; i++) begin
         drive(3'b100, i, 32'hFFFF_FFFF);
         tick();
      end
      drive(3'b000, 0, 32'h0);
      chk("mid_wrt_en_low", 256'(wrt_en), 256'(0));
      axis.tready = 1'b1;
      tick();
      axis.tready = 1'b0;
      chk("mid_count_13", 256'(dut.count_q), 256'(13));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_wrt_en", 256'(wrt_en), 256'(1));
      chk("mid_rst_tvalid", 256'(axis.tvalid), 256'(0));
      chk("mid_rst_pkt_len", 256'(pkt_len), 256'(0));
      chk("mid_rst_overflow", 256'(overflow_err), 256'(0));
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("mid_post_tvalid", 256'(axis.tvalid), 256'(0));
      axis.tready = 1'b1;
      drive(3'b101, 40, 32'h0000_000F);
      tick();
      chk("mid_new_head", axis.tdata, pat(40));
      drive(3'b000, 0, 32'h0);
      tick();
      chk("mid_new_strobe", 256'(pkt_len_valid), 256'(1));
      chk("mid_new_len", 256'(pkt_len), 256'(4));

      // Data/flags ignored without valid
      drive(3'b011, 50, 32'hFFFF_FFFF);
      tick();
      chk("novalid_tvalid", 256'(axis.tvalid), 256'(0));
      chk("novalid_stall", 256'(stall_cnt), 256'(0));

      // Stall counting and saturation
      for (int i = 0; i < 5; i++) begin
         drive(3'b110, 60 + i, 32'h0);
         tick();
      end
      drive(3'b000, 0, 32'h0);
      tick();
      chk("stall_5", 256'(stall_cnt), 256'(5));
      drive(3'b110, 70, 32'h0);
      for (int i = 0; i < 65530; i++) tick();
      chk("stall_ffff", 256'(stall_cnt), 256'(16'hFFFF));
      for (int i = 0; i < 3; i++) tick();
      chk("stall_saturate", 256'(stall_cnt), 256'(16'hFFFF));
      drive(3'b000, 0, 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aligner_out_buffer.md
ALIGNER_OUT_BUFFER -- requirements
Module: aligner_out_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, output beat width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 8).
REQ-003 SHALL have parameter SKID, default 3, free entries reserved for aligner in-flight beats.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  aligned beat from aligner data_out.
REQ-007 SHALL have port in_tkeep  input  DATA_WIDTH/8  byte-valid mask from aligner.
REQ-008 SHALL have port in_flags  input  3  {valid, stall, tlast} from aligner flags_out.
REQ-009 SHALL have port wrt_en  output  1  advance enable to aligner.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tlast/tvalid  output  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI4-Stream master.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have ports pkt_len  output  32  and pkt_len_valid  output  1  per-packet byte count and strobe.
REQ-013 SHALL have ports overflow_err  output  1  sticky drop flag; stall_cnt  output  16  aligner stall events.

Function
REQ-014 SHALL push {in_data, in_tkeep, tlast} when in_flags[2]=1 and (count<DEPTH or pop in same cycle).
REQ-015 SHALL drop a beat arriving when full with no same-cycle pop and set overflow_err=1 until reset.
REQ-016 SHALL be first-word-fall-through: m_axis_tvalid = (count!=0), tdata/tkeep/tlast = head entry, combinational from storage.
REQ-017 SHALL pop when m_axis_tvalid & m_axis_tready; held tvalid data SHALL stay stable until popped.
REQ-018 SHALL keep count in [0, DEPTH] with width clog2(DEPTH)+1; push+pop same cycle leaves count unchanged.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL drive wrt_en from a register: next value 1 iff (DEPTH - next_count) > SKID.
REQ-021 SHALL, with DEPTH=16, SKID=3, deassert wrt_en the cycle after count reaches 13, reassert the cycle after count falls to 12.
REQ-022 SHALL accumulate popcount(tkeep) of each popped beat in a 32-bit accumulator, wrapping mod 2^32.
REQ-023 SHALL on pop of a tlast beat register pkt_len = accumulator + popcount(beat), pulse pkt_len_valid for exactly one cycle, clear accumulator to 0.
REQ-024 SHALL hold pkt_len between strobes.
REQ-025 SHALL increment stall_cnt when in_flags[2:1]=2'b11, saturating at 16'hFFFF.
REQ-026 SHALL ignore in_tkeep/in_data/tlast when in_flags[2]=0.
REQ-027 SHALL have zero-cycle latency empty->tvalid after push register update (beat visible cycle after push).

Reset
REQ-028 SHALL on reset_n=0 asynchronously clear pointers, count, accumulator, pkt_len, pkt_len_valid, overflow_err, stall_cnt; set wrt_en=1.
REQ-029 SHALL drive m_axis_tvalid=0 during and after reset until a push; storage contents need not reset.
REQ-030 SHALL discard any partial packet and accumulator on mid-packet reset; no pkt_len_valid for it.

Structure
REQ-031 SHALL place DATA_WIDTH, KEEP_WIDTH, entry-width constant, and a keep-popcount function in shared package aligner_pkg.
REQ-032 SHALL instantiate one sub-module aligner_fifo_mem (DEPTH x (DATA_WIDTH+DATA_WIDTH/8+1), 1 write port, async read).

Verification
REQ-033 Reset: reset_n low mid-stream -> wrt_en=1, tvalid=0, pkt_len=0, overflow_err=0 immediately.
REQ-034 Single packet: 3 beats tkeep FFFFFFFF, FFFFFFFF, 0000000F with tlast on third, tready=1 -> 3 beats out in order, pkt_len=68, one-cycle strobe.
REQ-035 Backpressure: tready=0, 13 pushes -> wrt_en low next cycle; 3 more pushes accepted, count=16, overflow_err=0; tready=1 one beat -> count 15.
REQ-036 Overflow: full, tready=0, one extra valid beat -> beat dropped, overflow_err=1 sticky, count stays 16.
REQ-037 Simultaneous: full, push and pop same cycle -> both occur, count=16, output order preserved.
REQ-038 Stall counting: 5 cycles in_flags=3'b110 -> stall_cnt=5; preload 16'hFFFF plus one -> stays FFFF.
